// File: rtl/divide_scale_seq_if.sv
// divide_scale_seq_if: request/result bundle for the sequential scaled divider
interface divide_scale_seq_if #(
  parameter int INPUT_WIDTH   = 18,
  parameter int OUTPUT_WIDTH  = 9,
  parameter int DIVISOR_WIDTH = 8
);
  logic signed [INPUT_WIDTH-1:0]  dividend;
  logic        [DIVISOR_WIDTH-1:0] divisor;
  logic                            round_en;
  logic                            dividend_valid_n;
  logic                            ready_n;
  logic signed [OUTPUT_WIDTH-1:0] quotient;
  logic                            quotient_valid_n;
  logic                            div_zero;
  logic                            sat;
  modport master (
    output dividend, divisor, round_en, dividend_valid_n,
    input  ready_n, quotient, quotient_valid_n, div_zero, sat
  );
  modport slave (
    input  dividend, divisor, round_en, dividend_valid_n,
    output ready_n, quotient, quotient_valid_n, div_zero, sat
  );
endinterface

// File: rtl/divide_scale_seq.sv
// divide_scale_seq: signed dividend / (divisor << SHIFT), restoring, fixed latency
module divide_scale_seq #(
  parameter int INPUT_WIDTH   = 18,
  parameter int OUTPUT_WIDTH  = 9,
  parameter int DIVISOR_WIDTH = 8,
  parameter int SHIFT         = 8
) (
  input logic               clk_p,
  input logic               rst_n,
  divide_scale_seq_if.slave bus
);
  localparam int DW = DIVISOR_WIDTH + SHIFT;
  localparam int DW1 = DW + 1;
  localparam int MW = INPUT_WIDTH + 1;
  localparam int CW = $clog2(INPUT_WIDTH);
  localparam logic [CW-1:0] last = CW'(INPUT_WIDTH - 1);
  localparam logic [MW-1:0] max_pos = MW'((1 << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic [MW-1:0] max_neg = MW'(1 << (OUTPUT_WIDTH - 1));
  localparam logic [OUTPUT_WIDTH-1:0] max_q = OUTPUT_WIDTH'((1 << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic [OUTPUT_WIDTH-1:0] min_q = ~max_q;
  typedef enum logic [1:0] {IDLE, CALC, POST, DONE} state_t;
  state_t                   state;
  logic                     sign, rnd;
  logic [INPUT_WIDTH-1:0]   mag, q;
  logic [DIVISOR_WIDTH-1:0] dvs;
  logic [DW:0]              r, d, r_sh, r_nx;
  logic [CW-1:0]            cnt;
  logic                     ge, up, dz, sat_c, accept;
  logic [MW-1:0]            m;
  logic [OUTPUT_WIDTH-1:0]  q_c, q_out;
  logic                     rdy_n, vld_n, dz_out, sat_out;
  assign d = DW1'(dvs) << SHIFT;
  assign accept = !bus.dividend_valid_n && !rdy_n;
  assign bus.ready_n = rdy_n;
  assign bus.quotient = q_out;
  assign bus.quotient_valid_n = vld_n;
  assign bus.div_zero = dz_out;
  assign bus.sat = sat_out;
  // one restoring step plus the rounding, sign and clamp of the finished quotient
  always_comb begin
    r_sh = DW1'({r, mag[INPUT_WIDTH-1]});
    ge = r_sh >= d;
    r_nx = ge ? r_sh - d : r_sh;
    up = rnd && (DW1'({r, 1'b0}) >= d);
    m = MW'(q) + MW'(up);
    dz = dvs == '0;
    sat_c = dz || (sign ? m > max_neg : m > max_pos);
    q_c = sat_c ? (sign ? min_q : max_q) : (sign ? -m[OUTPUT_WIDTH-1:0] : m[OUTPUT_WIDTH-1:0]);
  end
  // control FSM: capture, INPUT_WIDTH division steps, finish, one-cycle strobe
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sign <= 1'b0;
      rnd <= 1'b0;
      mag <= '0;
      q <= '0;
      dvs <= '0;
      r <= '0;
      cnt <= '0;
      q_out <= '0;
      rdy_n <= 1'b0;
      vld_n <= 1'b1;
      dz_out <= 1'b0;
      sat_out <= 1'b0;
    end else begin
      vld_n <= 1'b1;
      case (state)
        CALC: begin
          r <= r_nx;
          q <= {q[INPUT_WIDTH-2:0], ge};
          mag <= mag << 1;
          cnt <= cnt + CW'(1);
          if (cnt == last) state <= POST;
        end
        POST: begin
          q_out <= q_c;
          dz_out <= dz;
          sat_out <= sat_c;
          vld_n <= 1'b0;
          rdy_n <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        sign <= bus.dividend[INPUT_WIDTH-1];
        mag <= bus.dividend[INPUT_WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs <= bus.divisor;
        rnd <= bus.round_en;
        r <= '0;
        q <= '0;
        cnt <= '0;
        rdy_n <= 1'b1;
        state <= CALC;
      end
    end
  end
endmodule

// File: tb/tb_divide_scale_seq.sv
// tb_divide_scale_seq: scoreboard bench for divide_scale_seq
module tb_divide_scale_seq;
  localparam int IW = 18;
  localparam int LAT = IW + 2;
  typedef struct {int q; int dz; int sat; int acc;} exp_t;
  logic clk_p = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  divide_scale_seq_if bus ();
  divide_scale_seq dut (.clk_p(clk_p), .rst_n(rst_n), .bus(bus));
  always #5 clk_p = ~clk_p;
  always @(posedge clk_p) cyc <= cyc + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(string tag, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask
  function automatic exp_t model(int dvd, int dvs, bit rnd, int acc);
    exp_t e;
    longint a, dd, qq, rem, m;
    e.acc = acc;
    e.dz = (dvs == 0);
    a = dvd < 0 ? -longint'(dvd) : longint'(dvd);
    dd = longint'(dvs) * 256;
    if (dvs == 0) begin
      e.q = dvd < 0 ? -256 : 255;
      e.sat = 1;
      return e;
    end
    qq = a / dd;
    rem = a % dd;
    m = qq + ((rnd && 2 * rem >= dd) ? 1 : 0);
    if (dvd < 0) begin
      e.sat = m > 256;
      e.q = e.sat ? -256 : -int'(m);
    end else begin
      e.sat = m > 255;
      e.q = e.sat ? 255 : int'(m);
    end
    return e;
  endfunction
  always @(negedge clk_p) begin : mon
    exp_t e;
    if (rst_n && bus.quotient_valid_n === 1'b0) begin
      if (sb.size() == 0) chk("spurious_strobe", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", int'(bus.quotient), e.q);
        chk("div_zero", int'(bus.div_zero), e.dz);
        chk("sat", int'(bus.sat), e.sat);
        chk("latency", cyc - e.acc + 1, LAT);
      end
    end
  end
  task automatic send(int dvd, int dvs, bit rnd);
    int n = 0;
    @(negedge clk_p);
    while (bus.ready_n !== 1'b0 && n < 100) begin
      @(negedge clk_p);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 1, 0);
    bus.dividend = IW'(dvd);
    bus.divisor = 8'(dvs);
    bus.round_en = rnd;
    bus.dividend_valid_n = 1'b0;
    sb.push_back(model(dvd, dvs, rnd, cyc + 1));
    @(negedge clk_p);
    bus.dividend_valid_n = 1'b1;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_p);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask
  initial begin
    int dirs[10][3] = '{
      '{76800, 3, 0}, '{-1152, 3, 0}, '{-1152, 3, 1}, '{-1000, 3, 1}, '{1151, 3, 1},
      '{131071, 1, 0}, '{-131072, 1, 0}, '{-65536, 1, 0}, '{-5, 0, 0}, '{0, 0, 0}};
    int extremes[4] = '{-131072, 131071, 0, -1};
    int accepted, last_acc, dvd, dvs;
    bit rnd;
    logic signed [IW-1:0] v;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.round_en = 1'b0;
    bus.dividend_valid_n = 1'b1;
    repeat (3) @(negedge clk_p);
    chk("rst_ready_n", int'(bus.ready_n), 0);
    chk("rst_valid_n", int'(bus.quotient_valid_n), 1);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_div_zero", int'(bus.div_zero), 0);
    chk("rst_sat", int'(bus.sat), 0);
    rst_n = 1'b1;
    foreach (dirs[i]) begin
      send(dirs[i][0], dirs[i][1], dirs[i][2][0]);
      drain();
    end
    send(12345, 7, 1'b1);
    repeat (7) @(negedge clk_p);
    rst_n = 1'b0;
    #1;
    chk("abort_ready_n", int'(bus.ready_n), 0);
    chk("abort_valid_n", int'(bus.quotient_valid_n), 1);
    chk("abort_quotient", int'(bus.quotient), 0);
    chk("abort_div_zero", int'(bus.div_zero), 0);
    chk("abort_sat", int'(bus.sat), 0);
    sb.delete();
    repeat (3) @(negedge clk_p);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_p);
    send(-100000, 200, 1'b1);
    drain();
    accepted = 0;
    last_acc = -1;
    for (int i = 0; accepted < 1500 && i < 40000; i++) begin
      @(negedge clk_p);
      v = IW'($urandom);
      dvd = $urandom_range(0, 7) == 0 ? extremes[$urandom_range(0, 3)] : int'(v);
      case ($urandom_range(0, 7))
        0: dvs = 0;
        1: dvs = 255;
        default: dvs = $urandom_range(1, 255);
      endcase
      rnd = 1'($urandom);
      bus.dividend = IW'(dvd);
      bus.divisor = 8'(dvs);
      bus.round_en = rnd;
      bus.dividend_valid_n = 1'b0;
      if (bus.ready_n === 1'b0) begin
        sb.push_back(model(dvd, dvs, rnd, cyc + 1));
        if (last_acc >= 0) chk("accept_spacing", cyc + 1 - last_acc, LAT);
        last_acc = cyc + 1;
        accepted++;
      end
    end
    @(negedge clk_p);
    bus.dividend_valid_n = 1'b1;
    drain();
    chk("sweep_count", accepted, 1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
